// File: rtl/cp0_timer_ctl.sv
// Coprocessor-0 beside the M stage: SR/Cause/EPC/PRId, Count/Compare timer, exception/interrupt arbitration.
// Optional BadVAddr register (index 8) is built when CP0_BADVADDR_EN is defined.
module cp0_timer_ctl #(
  parameter int unsigned NUM_HWINT = 5,
  parameter logic [31:0] PRID_VAL  = 32'h4255_4141
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 WE,
  input  logic [4:0]           CP0Add,
  input  logic [31:0]          CP0In,
  output logic [31:0]          CP0Out,
  input  logic [31:0]          VPC,
  input  logic                 BDIn,
  input  logic [4:0]           ExcCodeIn,
  input  logic [31:0]          BadVAddrIn,
  input  logic [NUM_HWINT-1:0] HWInt,
  input  logic                 EXLClr,
  output logic [31:0]          EPCOut,
  output logic                 Req,
  output logic                 TimerIrq
);

  localparam int unsigned PW = NUM_HWINT + 1;

  logic [31:0] sr, cause, epc, count, compare;
  logic [31:0] sr_next, cause_next, vpc_adj;
  logic [PW-1:0] pend, mask;
  logic exl, ie, exc_req, int_req;
  logic wr_sr, wr_epc, wr_count, wr_compare;

  assign pend = {TimerIrq, HWInt};
  assign mask = sr[10 +: PW];
  assign exl  = sr[1];
  assign ie   = sr[0];

  assign exc_req = !exl && (ExcCodeIn != 5'd0);
  assign int_req = !exl && ie && (|(pend & mask));
  assign Req     = exc_req | int_req;

  assign vpc_adj = BDIn ? (VPC - 32'd4) : VPC;
  assign EPCOut  = Req ? (vpc_adj & ~32'h3) : epc;

  // mtc0 is dropped whenever an exception/interrupt is taken in the same cycle
  assign wr_sr      = WE && !Req && (CP0Add == 5'd12);
  assign wr_epc     = WE && !Req && (CP0Add == 5'd14);
  assign wr_count   = WE && !Req && (CP0Add == 5'd9);
  assign wr_compare = WE && !Req && (CP0Add == 5'd11);

  always_comb begin
    sr_next = sr;
    if (Req) begin
      sr_next[1] = 1'b1;
    end else begin
      if (EXLClr) sr_next[1] = 1'b0;
      if (wr_sr)  sr_next = CP0In;
    end
  end

  // Pending lines are sampled every cycle; BD and ExcCode only change on a taken request
  always_comb begin
    cause_next          = '0;
    cause_next[31]      = Req ? BDIn : cause[31];
    cause_next[6:2]     = Req ? (int_req ? 5'd0 : ExcCodeIn) : cause[6:2];
    cause_next[10 +: PW] = pend;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr       <= '0;
      cause    <= '0;
      epc      <= '0;
      count    <= '0;
      compare  <= '0;
      TimerIrq <= 1'b0;
    end else begin
      sr    <= sr_next;
      cause <= cause_next;
      if (Req)         epc <= EPCOut;
      else if (wr_epc) epc <= CP0In & ~32'h3;
      count <= wr_count ? CP0In : count + 32'd1;
      if (wr_compare) compare <= CP0In;
      if (wr_compare)
        TimerIrq <= 1'b0;
      else if ((count == compare) && (compare != 32'd0))
        TimerIrq <= 1'b1;
    end
  end

`ifdef CP0_BADVADDR_EN
  logic [31:0] bad_vaddr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      bad_vaddr <= '0;
    else if (exc_req && !int_req && ((ExcCodeIn == 5'd4) || (ExcCodeIn == 5'd5)))
      bad_vaddr <= BadVAddrIn;
  end
`else
  logic unused_badvaddr;
  assign unused_badvaddr = ^BadVAddrIn;
`endif

  always_comb begin
    CP0Out = '0;
    case (CP0Add)
`ifdef CP0_BADVADDR_EN
      5'd8:    CP0Out = bad_vaddr;
`endif
      5'd9:    CP0Out = count;
      5'd11:   CP0Out = compare;
      5'd12:   CP0Out = sr;
      5'd13:   CP0Out = cause;
      5'd14:   CP0Out = epc;
      5'd15:   CP0Out = PRID_VAL;
      default: CP0Out = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_timer_ctl.sv
// Directed self-checking bench for cp0_timer_ctl with hand-computed expectations.
module tb_cp0_timer_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE;
  logic [4:0]  CP0Add;
  logic [31:0] CP0In;
  logic [31:0] CP0Out;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [31:0] BadVAddrIn;
  logic [4:0]  HWInt;
  logic        EXLClr;
  logic [31:0] EPCOut;
  logic        Req;
  logic        TimerIrq;

  int checks = 0;
  int failures = 0;
  logic [31:0] v;

  cp0_timer_ctl #(.NUM_HWINT(5), .PRID_VAL(32'h4255_4141)) dut (
    .clk(clk), .reset(reset), .WE(WE), .CP0Add(CP0Add), .CP0In(CP0In),
    .CP0Out(CP0Out), .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn),
    .BadVAddrIn(BadVAddrIn), .HWInt(HWInt), .EXLClr(EXLClr),
    .EPCOut(EPCOut), .Req(Req), .TimerIrq(TimerIrq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] val);
    CP0Add = a;
    #1;
    val = CP0Out;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    WE = 1'b1; CP0Add = a; CP0In = d;
    tick();
    WE = 1'b0;
  endtask

  initial begin
    reset = 1'b1; WE = 1'b0; CP0Add = '0; CP0In = '0; VPC = '0; BDIn = 1'b0;
    ExcCodeIn = '0; BadVAddrIn = '0; HWInt = '0; EXLClr = 1'b0;
    tick();
    rd(5'd9, v);  chk("rst_count", v, 32'h0);
    rd(5'd15, v); chk("prid", v, 32'h4255_4141);
    chk("rst_req", {31'd0, Req}, 32'h0);
    chk("rst_timerirq", {31'd0, TimerIrq}, 32'h0);
    chk("rst_epcout", EPCOut, 32'h0);
    tick();
    reset = 1'b0;

    // Async reset mid-run with Count=50
    mtc0(5'd9, 32'd50);
    rd(5'd9, v); chk("count_written", v, 32'd50);
    reset = 1'b1;
    rd(5'd9, v);  chk("async_rst_count", v, 32'h0);
    rd(5'd12, v); chk("async_rst_sr", v, 32'h0);
    chk("async_rst_req", {31'd0, Req}, 32'h0);
    tick();
    reset = 1'b0;

    // Hardware interrupt in a delay slot
    mtc0(5'd12, 32'h0000_0401);
    HWInt = 5'b00001; VPC = 32'h3008; BDIn = 1'b1;
    #1;
    chk("int_req", {31'd0, Req}, 32'h1);
    chk("int_epcout", EPCOut, 32'h3004);
    tick();
    rd(5'd13, v); chk("int_cause", v, 32'h8000_0400);
    rd(5'd12, v); chk("int_sr_exl", v, 32'h0000_0403);
    chk("int_req_masked_by_exl", {31'd0, Req}, 32'h0);
    rd(5'd14, v); chk("int_epc", v, 32'h3004);
    HWInt = '0; BDIn = 1'b0;

    // Exception drops same-cycle mtc0
    mtc0(5'd12, 32'h0);
    WE = 1'b1; CP0Add = 5'd14; CP0In = 32'h5000; ExcCodeIn = 5'd10; VPC = 32'h3010;
    #1;
    chk("exc_req", {31'd0, Req}, 32'h1);
    chk("exc_epcout", EPCOut, 32'h3010);
    tick();
    WE = 1'b0; ExcCodeIn = '0;
    rd(5'd14, v); chk("exc_epc_mtc0_dropped", v, 32'h3010);
    rd(5'd13, v); chk("exc_cause", v, 32'h0000_0028);
    rd(5'd12, v); chk("exc_sr", v, 32'h0000_0002);

    // EXL blocks requests; eret clears EXL and pending interrupt follows
    mtc0(5'd12, 32'h0000_0403);
    HWInt = 5'b00001; ExcCodeIn = 5'd10; EXLClr = 1'b1;
    #1;
    chk("exl_blocks_req", {31'd0, Req}, 32'h0);
    tick();
    EXLClr = 1'b0; ExcCodeIn = '0;
    rd(5'd12, v); chk("eret_sr", v, 32'h0000_0401);
    chk("post_eret_req", {31'd0, Req}, 32'h1);
    HWInt = '0;
    #1;
    chk("req_drops_with_hwint", {31'd0, Req}, 32'h0);

    // EPC write masking and ignored index
    mtc0(5'd14, 32'h0000_1237);
    rd(5'd14, v); chk("epc_write_masked", v, 32'h0000_1234);
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, v); chk("cause_write_ignored", v, 32'h0000_0028);

    // Count wrap
    mtc0(5'd9, 32'hFFFF_FFFF);
    rd(5'd9, v); chk("count_max", v, 32'hFFFF_FFFF);
    tick();
    rd(5'd9, v); chk("count_wrap", v, 32'h0);

    // Timer interrupt
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd9, 32'd1000);
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("timer_low_%0d", i), {31'd0, TimerIrq}, 32'h0);
    end
    tick();
    chk("timer_set", {31'd0, TimerIrq}, 32'h1);
    chk("timer_req", {31'd0, Req}, 32'h1);
    tick();
    rd(5'd13, v); chk("timer_cause", v, 32'h0000_8000);
    chk("timer_req_exl", {31'd0, Req}, 32'h0);
    chk("timer_held", {31'd0, TimerIrq}, 32'h1);
    mtc0(5'd11, 32'd100);
    chk("timer_cleared", {31'd0, TimerIrq}, 32'h0);

    // Address-error exception and BadVAddr
    mtc0(5'd12, 32'h0);
    ExcCodeIn = 5'd4; BadVAddrIn = 32'h0000_3003;
    tick();
    ExcCodeIn = '0;
`ifdef CP0_BADVADDR_EN
    rd(5'd8, v); chk("badvaddr_load", v, 32'h0000_3003);
    mtc0(5'd8, 32'h1);
    rd(5'd8, v); chk("badvaddr_readonly", v, 32'h0000_3003);
`else
    rd(5'd8, v); chk("reg8_zero", v, 32'h0);
    mtc0(5'd8, 32'h1);
    rd(5'd8, v); chk("reg8_zero_after_write", v, 32'h0);
`endif
    rd(5'd13, v); chk("adel_cause", v, 32'h0000_0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
